// File: rtl/enemy_stepper_if.sv
// enemy_stepper_if
//   Grid memory bus between the enemy stepper and the tile grid store.
//   The grid store is expected to return read data one clock after the
//   address is presented.
//
//   grid_x     [5:0]  cell column address      (stepper -> grid)
//   grid_y     [4:0]  cell row address         (stepper -> grid)
//   grid_write        write strobe             (stepper -> grid)
//   grid_in    [2:0]  write data (cell code)   (stepper -> grid)
//   grid_out   [2:0]  read data (cell code)    (grid -> stepper)
interface enemy_stepper_if;
  logic [5:0] grid_x;
  logic [4:0] grid_y;
  logic       grid_write;
  logic [2:0] grid_in;
  logic [2:0] grid_out;

  modport master (
    output grid_x,
    output grid_y,
    output grid_write,
    output grid_in,
    input  grid_out
  );

  modport slave (
    input  grid_x,
    input  grid_y,
    input  grid_write,
    input  grid_in,
    output grid_out
  );
endinterface

// File: rtl/enemy_stepper.sv
// enemy_stepper
//   Once per game tick, walks every grid cell and moves each enemy one cell
//   into an adjacent air cell, either rotating through directions (roam) or
//   heading toward the player (chase). Moved enemies are first marked with
//   MOVED_CODE so the raster scan cannot pick them up again; a second pass
//   turns every marked cell back into an enemy.
//
//   clock            rising-edge clock
//   resetn           asynchronous active-low reset
//   start            sweep request, honoured only while idle
//   chase_en         1 = chase the player, 0 = roam (latched at start)
//   player_x/_y      chase target (latched at start)
//   done             one-cycle pulse when a sweep request completes
//   busy             high whenever the stepper is not idle
//   move_count [7:0] enemies moved by the last completed sweep (saturating)
//   grid             grid memory bus (master side)
module enemy_stepper #(
  parameter int         GRID_W      = 40,
  parameter int         GRID_H      = 30,
  parameter int         TICK_CYCLES = 200000,
  parameter logic [2:0] ENEMY_CODE  = 3'd4,
  parameter logic [2:0] MOVED_CODE  = 3'd5,
  parameter logic [2:0] AIR_CODE    = 3'd0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   chase_en,
  input  logic [5:0]             player_x,
  input  logic [4:0]             player_y,
  output logic                   done,
  output logic                   busy,
  output logic [7:0]             move_count,
  enemy_stepper_if.master        grid
);

  localparam int               TW            = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]    C_TICK_RELOAD = TW'(TICK_CYCLES - 1);
  localparam logic [5:0]       C_LAST_X      = 6'(GRID_W - 1);
  localparam logic [4:0]       C_LAST_Y      = 5'(GRID_H - 1);
  localparam logic signed [7:0] C_W_S        = 8'(GRID_W);
  localparam logic signed [7:0] C_H_S        = 8'(GRID_H);

  typedef enum logic [3:0] {
    IDLE, CHECK_TICK, SCAN_ADDR, SCAN_READ, PICK_DIR, TGT_ADDR, TGT_READ,
    WRITE_NEW, WRITE_OLD, NEXT, FIX_ADDR, FIX_READ, FIX_WRITE, FIX_NEXT, DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [TW-1:0]   r_tick_cnt;
  logic            r_tick_pending;
  logic [5:0]      r_cx;
  logic [4:0]      r_cy;
  logic [1:0]      r_dir;
  logic            r_alt;
  logic [7:0]      r_moves;
  logic [7:0]      r_move_count;

  // Per-sweep operands and the chosen target; no reset needed, they are
  // always written before use.
  logic            r_chase;
  logic [5:0]      r_px;
  logic [4:0]      r_py;
  logic [5:0]      r_tx;
  logic [4:0]      r_ty;

  logic                w_tick;
  logic                w_last;
  logic signed [6:0]   w_dx;
  logic signed [6:0]   w_dy;
  logic                w_x_first;
  logic                w_use_x;
  logic signed [7:0]   w_sx;
  logic signed [7:0]   w_sy;
  logic signed [7:0]   w_tx;
  logic signed [7:0]   w_ty;
  logic                w_in_bounds;
  logic                w_no_move;
  logic                w_alt_ok;
  logic                w_tgt_sel;

  function automatic logic [6:0] abs7(input logic signed [6:0] v);
    return v[6] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_tick = (r_tick_cnt == '0);
  assign w_last = (r_cx == C_LAST_X) && (r_cy == C_LAST_Y);

  // Chase deltas as signed 7-bit values
  assign w_dx      = $signed({1'b0, r_px}) - $signed({1'b0, r_cx});
  assign w_dy      = $signed({2'b00, r_py}) - $signed({2'b00, r_cy});
  assign w_x_first = (abs7(w_dx) >= abs7(w_dy));
  assign w_no_move = r_chase && (w_dx == 7'sd0) && (w_dy == 7'sd0);
  // The other axis is tried only once, and only if it actually closes distance
  assign w_alt_ok  = r_chase && !r_alt &&
                     (w_x_first ? (w_dy != 7'sd0) : (w_dx != 7'sd0));

  always_comb begin
    w_use_x = 1'b0;
    w_sx    = 8'sd0;
    w_sy    = 8'sd0;
    if (r_chase) begin
      w_use_x = w_x_first ^ r_alt;
      if (w_use_x) w_sx = w_dx[6] ? -8'sd1 : 8'sd1;
      else         w_sy = w_dy[6] ? -8'sd1 : 8'sd1;
    end else begin
      case (r_dir)
        2'd0:    w_sy = -8'sd1;
        2'd1:    w_sx =  8'sd1;
        2'd2:    w_sy =  8'sd1;
        default: w_sx = -8'sd1;
      endcase
    end
  end

  assign w_tx = $signed({2'b00, r_cx}) + w_sx;
  assign w_ty = $signed({3'b000, r_cy}) + w_sy;
  // No wraparound: stepping off any edge is simply blocked
  assign w_in_bounds = (w_tx >= 8'sd0) && (w_tx < C_W_S) &&
                       (w_ty >= 8'sd0) && (w_ty < C_H_S);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (start) w_next = CHECK_TICK;
      CHECK_TICK: w_next = r_tick_pending ? SCAN_ADDR : DONE;
      SCAN_ADDR:  w_next = SCAN_READ;
      SCAN_READ:  w_next = (grid.grid_out == ENEMY_CODE) ? PICK_DIR : NEXT;
      PICK_DIR: begin
        if (w_no_move)        w_next = NEXT;
        else if (w_in_bounds) w_next = TGT_ADDR;
        else if (w_alt_ok)    w_next = PICK_DIR;
        else                  w_next = NEXT;
      end
      TGT_ADDR:   w_next = TGT_READ;
      TGT_READ: begin
        if (grid.grid_out == AIR_CODE) w_next = WRITE_NEW;
        else if (w_alt_ok)             w_next = PICK_DIR;
        else                           w_next = NEXT;
      end
      WRITE_NEW:  w_next = WRITE_OLD;
      WRITE_OLD:  w_next = NEXT;
      NEXT:       w_next = w_last ? FIX_ADDR : SCAN_ADDR;
      FIX_ADDR:   w_next = FIX_READ;
      FIX_READ:   w_next = (grid.grid_out == MOVED_CODE) ? FIX_WRITE : FIX_NEXT;
      FIX_WRITE:  w_next = FIX_NEXT;
      FIX_NEXT:   w_next = w_last ? DONE : FIX_ADDR;
      DONE:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // A tick landing in the same cycle as the sweep-start clear wins
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_tick_cnt     <= C_TICK_RELOAD;
      r_tick_pending <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? C_TICK_RELOAD : r_tick_cnt - 1'b1;
      if (w_tick)                       r_tick_pending <= 1'b1;
      else if (r_state == CHECK_TICK)   r_tick_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cx         <= '0;
      r_cy         <= '0;
      r_dir        <= '0;
      r_alt        <= 1'b0;
      r_moves      <= '0;
      r_move_count <= '0;
    end else begin
      case (r_state)
        CHECK_TICK: begin
          r_moves <= '0;
          r_cx    <= '0;
          r_cy    <= '0;
        end
        SCAN_READ: r_alt <= 1'b0;
        PICK_DIR: begin
          if (!r_chase) r_dir <= r_dir + 2'd1;
          if (w_next == PICK_DIR) r_alt <= 1'b1;
        end
        TGT_READ:  if (w_next == PICK_DIR) r_alt <= 1'b1;
        WRITE_OLD: r_moves <= sat_inc8(r_moves);
        NEXT, FIX_NEXT: begin
          if (w_last) begin
            r_cx <= '0;
            r_cy <= '0;
          end else if (r_cx == C_LAST_X) begin
            r_cx <= '0;
            r_cy <= r_cy + 5'd1;
          end else begin
            r_cx <= r_cx + 6'd1;
          end
        end
        DONE:      r_move_count <= r_moves;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == IDLE && start) begin
      r_chase <= chase_en;
      r_px    <= player_x;
      r_py    <= player_y;
    end
    if (r_state == PICK_DIR) begin
      r_tx <= w_tx[5:0];
      r_ty <= w_ty[4:0];
    end
  end

  // Address is a pure function of state and held registers, so it stays
  // stable across every ADDR/READ pair and is zero whenever reset is active.
  assign w_tgt_sel = (r_state == TGT_ADDR) || (r_state == TGT_READ) ||
                     (r_state == WRITE_NEW);

  always_comb begin
    grid.grid_write = 1'b0;
    grid.grid_in    = 3'd0;
    case (r_state)
      WRITE_NEW: begin grid.grid_write = 1'b1; grid.grid_in = MOVED_CODE; end
      WRITE_OLD: begin grid.grid_write = 1'b1; grid.grid_in = AIR_CODE;   end
      FIX_WRITE: begin grid.grid_write = 1'b1; grid.grid_in = ENEMY_CODE; end
      default: ;
    endcase
  end

  assign grid.grid_x = w_tgt_sel ? r_tx : r_cx;
  assign grid.grid_y = w_tgt_sel ? r_ty : r_cy;
  assign done        = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign move_count  = r_move_count;

endmodule
